// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: sequencer states and arbiter grant codes.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WAIT,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M1   = 2'b01;
  localparam logic [1:0] GRANT_M2   = 2'b10;

  // Only the two real masters may open a transaction; 11 is treated as no owner.
  function automatic logic grant_valid(input logic [1:0] g);
    return (g == GRANT_M1) || (g == GRANT_M2);
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// WAIT-phase watchdog for bus_txn_sequencer.
// Only built when BUS_TXN_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef BUS_TXN_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES);

  logic [W-1:0] count_q, count_d;

  // Counter sits at 0 on the first counted cycle, so CYCLES-1 marks the last allowed one.
  assign expired = (count_q == W'(CYCLES - 1));

  // Next count: clear wins, otherwise advance until expiry.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/bus_txn_sequencer.sv
// Slave-side transaction sequencer: deserializes the granted master's header
// (slave index MSB first, then rw bit), enables the addressed slave, waits for
// its ready and pulses done/err back to the arbiter.
// Optional WAIT timeout is compiled in with BUS_TXN_TIMEOUT_EN.
module bus_txn_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned SLAVE_COUNT    = 3,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             bus_grant,
  input  logic                   m_valid,
  input  logic                   m_bit,
  input  logic [SLAVE_COUNT-1:0] slave_ready,
  output logic [SLAVE_COUNT-1:0] slave_en,
  output logic                   slave_rw,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CNT_W = $clog2(IDX_W + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             owner_q, owner_d;
  logic [SLAVE_COUNT-1:0] slave_en_q, slave_en_d;
  logic                   slave_rw_q, slave_rw_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic grant_lost;
  logic ready_hit;
  logic rw_bit;
  logic timeout_hit;

  assign grant_lost = (bus_grant != owner_q);
  // slave_en_q is one-hot on the addressed slave in WAIT, so masking filters other slaves.
  assign ready_hit  = |(slave_ready & slave_en_q);

`ifdef BUS_TXN_TIMEOUT_EN
  logic to_expired;

  bus_timeout_counter #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != WAIT),
    .enable ((state_q == WAIT) && !ready_hit),
    .expired(to_expired)
  );

  assign timeout_hit = to_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rw_bit  = slave_rw_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid(bus_grant) && m_valid) begin
          idx_d   = IDX_W'(m_bit);
          owner_d = bus_grant;
          cnt_d   = CNT_W'(1);
          state_d = HDR;
        end
      end
      HDR: begin
        if (grant_lost) begin
          cnt_d   = '0;
          state_d = ERR;
        end else if (m_valid) begin
          if (cnt_q == CNT_W'(IDX_W)) begin
            rw_bit  = m_bit;
            cnt_d   = '0;
            state_d = (32'(idx_q) < SLAVE_COUNT) ? WAIT : ERR;
          end else begin
            idx_d = (idx_q << 1) | IDX_W'(m_bit);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (grant_lost) begin
          state_d = ERR;
        end else if (ready_hit) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    slave_en_d = (state_d == WAIT) ? (SLAVE_COUNT'(1) << idx_d) : '0;
    slave_rw_d = (state_d == WAIT) ? rw_bit : 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      owner_q    <= GRANT_NONE;
      slave_en_q <= '0;
      slave_rw_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      slave_en_q <= slave_en_d;
      slave_rw_q <= slave_rw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign slave_en = slave_en_q;
  assign slave_rw = slave_rw_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Directed bench for bus_txn_sequencer; timeout cases follow BUS_TXN_TIMEOUT_EN.
module tb_bus_txn_sequencer;

  localparam int unsigned SC = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    bus_grant;
  logic          m_valid;
  logic          m_bit;
  logic [SC-1:0] slave_ready;
  logic [SC-1:0] slave_en;
  logic          slave_rw;
  logic [1:0]    owner;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bus_txn_sequencer #(
    .SLAVE_COUNT   (SC),
    .IDX_W         (IW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_grant  (bus_grant),
    .m_valid    (m_valid),
    .m_bit      (m_bit),
    .slave_ready(slave_ready),
    .slave_en   (slave_en),
    .slave_rw   (slave_rw),
    .owner      (owner),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    m_valid = 1'b1;
    m_bit   = b;
    step();
    m_valid = 1'b0;
    m_bit   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_en"},   32'(slave_en), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy),     32'h0);
    check_eq({tag, "_done"}, 32'(done),     32'h0);
    check_eq({tag, "_err"},  32'(err),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int high;

    reset       = 1'b0;
    bus_grant   = 2'b00;
    m_valid     = 1'b0;
    m_bit       = 1'b0;
    slave_ready = '0;
    step();
    step();
    check_quiet("rst");
    check_eq("rst_rw",    32'(slave_rw), 32'h0);
    check_eq("rst_owner", 32'(owner),    32'h0);
    reset = 1'b1;
    step();

    // Master 1 writes slave 2 (header 1,0,1).
    bus_grant = 2'b01;
    send_bit(1'b1);
    check_eq("t1_busy",  32'(busy),     32'h1);
    check_eq("t1_owner", 32'(owner),    32'h1);
    check_eq("t1_en0",   32'(slave_en), 32'h0);
    send_bit(1'b0);
    check_eq("t1_en1",   32'(slave_en), 32'h0);
    send_bit(1'b1);
    check_eq("t1_en",    32'(slave_en), 32'h4);
    check_eq("t1_rw",    32'(slave_rw), 32'h1);
    slave_ready = 3'b011;
    step();
    check_eq("t1_other_ready_en",   32'(slave_en), 32'h4);
    check_eq("t1_other_ready_done", 32'(done),     32'h0);
    slave_ready = 3'b100;
    step();
    slave_ready = '0;
    check_eq("t1_done",      32'(done),     32'h1);
    check_eq("t1_done_en",   32'(slave_en), 32'h0);
    check_eq("t1_done_busy", 32'(busy),     32'h1);
    step();
    check_quiet("t1_idle");

    // Master 2 reads slave 1 with a two-cycle gap after the first bit.
    bus_grant = 2'b10;
    send_bit(1'b0);
    m_bit = 1'b1;
    step();
    step();
    m_bit = 1'b0;
    check_eq("t2_gap_en",   32'(slave_en), 32'h0);
    check_eq("t2_gap_busy", 32'(busy),     32'h1);
    send_bit(1'b1);
    check_eq("t2_en_early", 32'(slave_en), 32'h0);
    send_bit(1'b0);
    check_eq("t2_en",    32'(slave_en), 32'h2);
    check_eq("t2_rw",    32'(slave_rw), 32'h0);
    check_eq("t2_owner", 32'(owner),    32'h2);
    slave_ready = 3'b010;
    step();
    slave_ready = '0;
    check_eq("t2_done", 32'(done), 32'h1);
    // A bit offered during DONE is dropped; the same bit is taken once IDLE.
    m_valid = 1'b1;
    m_bit   = 1'b1;
    step();
    check_eq("t2_done_no_accept", 32'(busy), 32'h0);
    step();
    m_valid = 1'b0;
    m_bit   = 1'b0;
    check_eq("t2_idle_accept", 32'(busy), 32'h1);
    bus_grant = 2'b00;
    step();
    check_eq("t2_hdr_loss_err", 32'(err),      32'h1);
    check_eq("t2_hdr_loss_en",  32'(slave_en), 32'h0);
    step();
    check_quiet("t2_idle");

    // Index 3 does not exist: error straight after the rw bit.
    bus_grant = 2'b01;
    send_bit(1'b1);
    check_eq("t3_en_a", 32'(slave_en), 32'h0);
    send_bit(1'b1);
    check_eq("t3_en_b", 32'(slave_en), 32'h0);
    send_bit(1'b0);
    check_eq("t3_err",  32'(err),      32'h1);
    check_eq("t3_en_c", 32'(slave_en), 32'h0);
    check_eq("t3_done", 32'(done),     32'h0);
    step();
    check_quiet("t3_idle");

    // Grant loss in WAIT beats a simultaneous ready.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("t4_en", 32'(slave_en), 32'h1);
    check_eq("t4_rw", 32'(slave_rw), 32'h1);
    bus_grant   = 2'b00;
    slave_ready = 3'b001;
    step();
    slave_ready = '0;
    check_eq("t4_err",  32'(err),      32'h1);
    check_eq("t4_done", 32'(done),     32'h0);
    check_eq("t4_en0",  32'(slave_en), 32'h0);
    step();
    check_quiet("t4_idle");

    // Slave 0 never answers.
    bus_grant = 2'b01;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check_eq("t5_en", 32'(slave_en), 32'h1);
`ifdef BUS_TXN_TIMEOUT_EN
    high = 0;
    for (int i = 0; i < 40 && slave_en != '0; i++) begin
      high++;
      step();
    end
    check_eq("t5_high_cycles", 32'(high), 32'(TO));
    check_eq("t5_timeout_err", 32'(err),  32'h1);
    step();
    check_quiet("t5_idle");
    // Ready on the last allowed WAIT cycle still completes.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (TO - 1) step();
    check_eq("t5b_en_last", 32'(slave_en), 32'h1);
    slave_ready = 3'b001;
    step();
    slave_ready = '0;
    check_eq("t5b_done", 32'(done), 32'h1);
    check_eq("t5b_err",  32'(err),  32'h0);
    step();
`else
    high = 0;
    for (int i = 0; i < 40; i++) begin
      if (slave_en == 3'b001 && !err) high++;
      step();
    end
    check_eq("t5_hold_cycles", 32'(high),     32'd40);
    check_eq("t5_hold_en",     32'(slave_en), 32'h1);
    slave_ready = 3'b001;
    step();
    slave_ready = '0;
    check_eq("t5_done", 32'(done), 32'h1);
    check_eq("t5_err",  32'(err),  32'h0);
    step();
`endif
    check_quiet("t5_idle_end");

    // Asynchronous reset while in WAIT.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check_eq("t6_en", 32'(slave_en), 32'h4);
    step();
    #2;
    reset = 1'b0;
    #1;
    check_quiet("t6_async");
    check_eq("t6_rw",    32'(slave_rw), 32'h0);
    check_eq("t6_owner", 32'(owner),    32'h0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t6_post_done", 32'(done), 32'h0);
      check_eq("t6_post_err",  32'(err),  32'h0);
      check_eq("t6_post_busy", 32'(busy), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
